// File: rtl/mem_responder_pkg.sv
// Shared definitions for the MIC-1 memory responder: request bit positions, FSM state
// and the return-tag format carried alongside RAM latency.
package mem_responder_pkg;

   localparam int NBITS = 32;
   localparam int WORD  = 32;

   localparam int MEM_WR    = 2;
   localparam int MEM_RD    = 1;
   localparam int MEM_FETCH = 0;

   typedef enum logic {S_ACCEPT, S_PEND_FETCH} mem_state_t;

   typedef struct packed {
      logic       rd;
      logic       fetch;
      logic [1:0] lane;
   } mem_tag_t;

endpackage

// File: rtl/mem_responder_byte_lane_select.sv
// Picks one byte lane out of a RAM word for the MBR path (lane 0 = bits 7:0).
module byte_lane_select #(
   parameter int WORD = 32
) (
   input  logic [WORD-1:0] rdata,
   input  logic [1:0]      lane,
   output logic [7:0]      data
);

   always_comb begin
      data = rdata[7:0];
      unique case (lane)
         2'd0: data = rdata[7:0];
         2'd1: data = rdata[15:8];
         2'd2: data = rdata[23:16];
         2'd3: data = rdata[31:24];
         default: data = rdata[7:0];
      endcase
   end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: sequences write/read/fetch requests onto a single-port synchronous
// RAM and returns data to MDR/MBR through a 2-stage tag pipeline matching RAM latency.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int NBITS  = mem_responder_pkg::NBITS,
   parameter int WORD   = mem_responder_pkg::WORD,
   parameter int RAM_AW = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        mem_control,
   input  logic [NBITS-1:0]  mar,
   input  logic [WORD-1:0]   mdr_out,
   input  logic [NBITS-1:0]  pc,
   output logic [WORD-1:0]   mdr_in,
   output logic              mdr_load,
   output logic [7:0]        mbr_in,
   output logic              mbr_load,
   output logic              busy,
   output logic              req_err,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [WORD-1:0]   ram_wdata,
   output logic              ram_we,
   input  logic [WORD-1:0]   ram_rdata
);

   mem_state_t        state;
   mem_tag_t          tag_q1;
   mem_tag_t          tag_q2;
   logic [RAM_AW-1:0] pend_addr;
   logic [1:0]        pend_lane;
   logic [WORD-1:0]   mdr_hold;
   logic [7:0]        mbr_hold;
   logic [7:0]        lane_byte;
   logic              wr_req;
   logic              rd_req;
   logic              fetch_req;
   logic              unused_addr_bits;

   assign wr_req    = mem_control[MEM_WR];
   assign rd_req    = mem_control[MEM_RD];
   assign fetch_req = mem_control[MEM_FETCH];

   // Addresses wrap within the RAM; the upper bits are intentionally dropped.
   assign unused_addr_bits = ^{mar[NBITS-1:RAM_AW], pc[NBITS-1:RAM_AW+2]};

   byte_lane_select #(
      .WORD(WORD)
   ) u_lane (
      .rdata(ram_rdata),
      .lane (tag_q2.lane),
      .data (lane_byte)
   );

   // RAM q is only valid in the return cycle, so data passes through then and is held after.
   assign mdr_load = tag_q2.rd;
   assign mbr_load = tag_q2.fetch;
   assign mdr_in   = tag_q2.rd ? ram_rdata : mdr_hold;
   assign mbr_in   = tag_q2.fetch ? lane_byte : mbr_hold;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_ACCEPT;
         tag_q1    <= '0;
         tag_q2    <= '0;
         pend_addr <= '0;
         pend_lane <= '0;
         mdr_hold  <= '0;
         mbr_hold  <= '0;
         busy      <= 1'b0;
         req_err   <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         ram_we    <= 1'b0;
      end else begin
         ram_we  <= 1'b0;
         req_err <= 1'b0;
         busy    <= 1'b0;
         tag_q1  <= '0;
         tag_q2  <= tag_q1;
         if (tag_q2.rd)    mdr_hold <= ram_rdata;
         if (tag_q2.fetch) mbr_hold <= lane_byte;

         unique case (state)
            S_ACCEPT: begin
               if (wr_req) begin
                  ram_addr  <= mar[RAM_AW-1:0];
                  ram_wdata <= mdr_out;
                  ram_we    <= 1'b1;
                  if (rd_req) req_err <= 1'b1;
               end else if (rd_req) begin
                  ram_addr <= mar[RAM_AW-1:0];
                  tag_q1   <= '{rd: 1'b1, fetch: 1'b0, lane: 2'b00};
               end else if (fetch_req) begin
                  ram_addr <= pc[RAM_AW+1:2];
                  tag_q1   <= '{rd: 1'b0, fetch: 1'b1, lane: pc[1:0]};
               end
               // A fetch riding with a read/write takes the port one cycle later.
               if (fetch_req && (wr_req || rd_req)) begin
                  pend_addr <= pc[RAM_AW+1:2];
                  pend_lane <= pc[1:0];
                  busy      <= 1'b1;
                  state     <= S_PEND_FETCH;
               end
            end
            S_PEND_FETCH: begin
               ram_addr <= pend_addr;
               tag_q1   <= '{rd: 1'b0, fetch: 1'b1, lane: pend_lane};
               if (mem_control != 3'b000) req_err <= 1'b1;
               state <= S_ACCEPT;
            end
            default: state <= S_ACCEPT;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized and directed bench for mem_responder against a transaction-level model with a
// shadow memory and per-cycle expected-event slots.
module tb_mem_responder;

   localparam logic [2:0] WR = 3'b100;
   localparam logic [2:0] RD = 3'b010;
   localparam logic [2:0] FE = 3'b001;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  mem_control;
   logic [31:0] mar, mdr_out, pc;
   logic [31:0] mdr_in;
   logic        mdr_load;
   logic [7:0]  mbr_in;
   logic        mbr_load;
   logic        busy, req_err;
   logic [15:0] ram_addr;
   logic [31:0] ram_wdata;
   logic        ram_we;
   logic [31:0] ram_rdata = '0;

   mem_responder dut (
      .clk        (clk),
      .reset      (reset),
      .mem_control(mem_control),
      .mar        (mar),
      .mdr_out    (mdr_out),
      .pc         (pc),
      .mdr_in     (mdr_in),
      .mdr_load   (mdr_load),
      .mbr_in     (mbr_in),
      .mbr_load   (mbr_load),
      .busy       (busy),
      .req_err    (req_err),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_we     (ram_we),
      .ram_rdata  (ram_rdata)
   );

   always #5 clk = ~clk;

   // Environment RAM: synchronous single port with registered output.
   logic [31:0] ram [0:65535];
   always @(posedge clk) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      ram_rdata <= ram[ram_addr];
   end

   // Reference model state.
   logic [31:0] shadow [0:65535];
   int          cyc;
   int          m_busy_cyc;
   logic [31:0] m_mdr;
   logic [7:0]  m_mbr;
   bit          e_mdr_ld [8];
   logic [31:0] e_mdr_val [8];
   bit          e_mbr_ld [8];
   logic [7:0]  e_mbr_val [8];
   bit          e_err [8];
   bit          e_busy [8];
   bit          e_we [8];
   bit          e_addr_v [8];
   logic [15:0] e_addr [8];
   logic [31:0] e_wdata [8];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, act, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < 8; i++) begin
         e_mdr_ld[i] = 0; e_mbr_ld[i] = 0; e_err[i] = 0; e_busy[i] = 0;
         e_we[i] = 0; e_addr_v[i] = 0; e_mdr_val[i] = '0; e_mbr_val[i] = '0;
         e_addr[i] = '0; e_wdata[i] = '0;
      end
      m_busy_cyc = -1;
      m_mdr = '0;
      m_mbr = '0;
   endtask

   function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] lane);
      return w[8*lane +: 8];
   endfunction

   // Schedules the visible consequences of a request issued in the current cycle.
   task automatic model_request(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] p);
      int s1, s2, s3;
      logic [15:0] wa, fa;
      s1 = (cyc + 1) % 8; s2 = (cyc + 2) % 8; s3 = (cyc + 3) % 8;
      wa = a[15:0];
      fa = p[17:2];
      if (ctl == 3'b000) return;
      if (cyc == m_busy_cyc) begin
         e_err[s1] = 1;
         return;
      end
      if (ctl[2]) begin
         shadow[wa] = d;
         e_we[s1] = 1; e_wdata[s1] = d; e_addr_v[s1] = 1; e_addr[s1] = wa;
         if (ctl[1]) e_err[s1] = 1;
      end else if (ctl[1]) begin
         e_addr_v[s1] = 1; e_addr[s1] = wa;
         e_mdr_ld[s2] = 1; e_mdr_val[s2] = shadow[wa];
      end
      if (ctl[0]) begin
         if (ctl[2] || ctl[1]) begin
            m_busy_cyc = cyc + 1;
            e_busy[s1] = 1;
            e_addr_v[s2] = 1; e_addr[s2] = fa;
            e_mbr_ld[s3] = 1; e_mbr_val[s3] = byte_of(shadow[fa], p[1:0]);
         end else begin
            e_addr_v[s1] = 1; e_addr[s1] = fa;
            e_mbr_ld[s2] = 1; e_mbr_val[s2] = byte_of(shadow[fa], p[1:0]);
         end
      end
   endtask

   task automatic check_cycle();
      int s;
      s = cyc % 8;
      if (e_mdr_ld[s]) m_mdr = e_mdr_val[s];
      if (e_mbr_ld[s]) m_mbr = e_mbr_val[s];
      check_eq("mdr_load", {31'b0, mdr_load}, {31'b0, e_mdr_ld[s]});
      check_eq("mdr_in", mdr_in, m_mdr);
      check_eq("mbr_load", {31'b0, mbr_load}, {31'b0, e_mbr_ld[s]});
      check_eq("mbr_in", {24'b0, mbr_in}, {24'b0, m_mbr});
      check_eq("req_err", {31'b0, req_err}, {31'b0, e_err[s]});
      check_eq("busy", {31'b0, busy}, {31'b0, e_busy[s]});
      check_eq("ram_we", {31'b0, ram_we}, {31'b0, e_we[s]});
      if (e_addr_v[s]) check_eq("ram_addr", {16'b0, ram_addr}, {16'b0, e_addr[s]});
      if (e_we[s]) check_eq("ram_wdata", ram_wdata, e_wdata[s]);
      e_mdr_ld[s] = 0; e_mbr_ld[s] = 0; e_err[s] = 0; e_busy[s] = 0;
      e_we[s] = 0; e_addr_v[s] = 0;
   endtask

   task automatic step(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] p);
      mem_control = ctl; mar = a; mdr_out = d; pc = p;
      model_request(ctl, a, d, p);
      @(posedge clk);
      #1;
      cyc++;
      check_cycle();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(3'b000, '0, '0, '0);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_mdr_load"}, {31'b0, mdr_load}, 32'd0);
      check_eq({tag, "_mbr_load"}, {31'b0, mbr_load}, 32'd0);
      check_eq({tag, "_ram_we"}, {31'b0, ram_we}, 32'd0);
      check_eq({tag, "_busy"}, {31'b0, busy}, 32'd0);
      check_eq({tag, "_req_err"}, {31'b0, req_err}, 32'd0);
      check_eq({tag, "_ram_addr"}, {16'b0, ram_addr}, 32'd0);
      check_eq({tag, "_ram_wdata"}, ram_wdata, 32'd0);
      check_eq({tag, "_mdr_in"}, mdr_in, 32'd0);
      check_eq({tag, "_mbr_in"}, {24'b0, mbr_in}, 32'd0);
   endtask

   // Asserts reset in the middle of the current cycle and holds it for two edges.
   task automatic mid_cycle_reset();
      mem_control = 3'b000;
      #3;
      reset = 1'b1;
      #1;
      check_all_zero("rst_async");
      clear_model();
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         check_cycle();
      end
      reset = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) begin
         ram[i] = i * 32'h0101_0007 + 32'h1234_5678;
         shadow[i] = ram[i];
      end
      ram[5] = 32'hDEADBEEF; shadow[5] = 32'hDEADBEEF;
      ram[2] = 32'h11223344; shadow[2] = 32'h11223344;
      cyc = 0;
      clear_model();
      reset = 1'b1;
      mem_control = '0; mar = '0; mdr_out = '0; pc = '0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      reset = 1'b0;

      // 1: plain read
      step(RD, 32'd5, '0, '0);
      idle(3);
      check_eq("s1_mdr_hold", mdr_in, 32'hDEADBEEF);
      // 2: fetch, pc=9 -> word 2 lane 1
      step(FE, '0, '0, 32'd9);
      idle(3);
      check_eq("s2_mbr_hold", {24'b0, mbr_in}, 32'h33);
      // 3: write then read-after-write
      step(WR, 32'd7, 32'hCAFEF00D, '0);
      step(RD, 32'd7, '0, '0);
      idle(3);
      check_eq("s3_mdr_hold", mdr_in, 32'hCAFEF00D);
      // 4: read+fetch collision, then ignored read while busy
      step(RD | FE, 32'd5, '0, 32'd8);
      step(RD, 32'd2, '0, '0);
      idle(3);
      check_eq("s4_mbr_hold", {24'b0, mbr_in}, 32'h44);
      check_eq("s4_mdr_hold", mdr_in, 32'hDEADBEEF);
      // 5: illegal write+read
      step(WR | RD, 32'd3, 32'h5, '0);
      idle(2);
      step(RD, 32'd3, '0, '0);
      idle(3);
      check_eq("s5_mdr_hold", mdr_in, 32'h5);
      // 6: reset while a read is in flight
      step(RD, 32'd5, '0, '0);
      mid_cycle_reset();
      step(RD, 32'd5, '0, '0);
      idle(3);
      check_eq("s6_mdr_hold", mdr_in, 32'hDEADBEEF);

      // Randomized traffic with wrapping addresses and one reset in the middle.
      for (int i = 0; i < 500; i++) begin
         logic [2:0]  ctl;
         logic [31:0] a, p;
         ctl = ($urandom_range(0, 9) < 3) ? 3'b000 : 3'($urandom_range(1, 7));
         a = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 15));
         p = ($urandom & 32'hFFFC_0000) | 32'($urandom_range(0, 63));
         if (i == 250) mid_cycle_reset();
         step(ctl, a, $urandom, p);
      end
      idle(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
